// File: rtl/rv_ifu_fetch.sv
// rv_ifu_fetch: RV32 instruction fetch stage.
// Holds the PC and issues word reads to the instruction RAM, which returns data one cycle later.
// Returned words go into a 2-entry buffer that feeds decode through a valid/ready handshake.
// A redirect from execute flushes all work in flight and reloads the PC.
// Optional feature: define IFU_PERF_CNT_EN to add the perf_fetch_cnt/perf_stall_cnt counters.
module rv_ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        sclk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        imem_rd,
  output logic        imem_wr,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_rdata
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CRD_W = 3;

  // Architectural and buffer state
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0]  fifo_pc_q    [2];
  logic [XLEN-1:0]  fifo_instr_q [2];

  // Handshake and issue qualifiers
  logic             pop_c;
  logic             push_c;
  logic             issue_c;
  logic [CRD_W-1:0] credit_c;
  logic [XLEN-1:0]  redirect_target_c;
  logic             unused_redirect_lsbs;

  assign redirect_target_c    = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign if_valid   = (cnt_q != CNT_W'(0));
  assign if_pc      = if_valid ? fifo_pc_q[rd_ptr_q]    : '0;
  assign if_instr   = if_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign imem_addr  = pc_q;
  assign imem_rd    = issue_c;
  assign imem_wr    = 1'b0;
  assign imem_wdata = '0;

  // Credit check: buffered + outstanding - leaving this cycle must leave room for one more
  always_comb begin
    pop_c    = if_valid & id_ready;
    push_c   = out_q & ~redirect_valid;
    credit_c = CRD_W'(cnt_q) + CRD_W'(out_q) - CRD_W'(pop_c);
    issue_c  = rstn & ~redirect_valid & (credit_c < CRD_W'(FIFO_DEPTH));
  end

  // Next-state: redirect wins over everything, otherwise advance PC, pointers and count
  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect_valid) begin
      pc_d     = redirect_target_c;
      out_d    = 1'b0;
      cnt_d    = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      out_d = issue_c;
      if (issue_c) begin
        pc_d     = pc_q + XLEN'(4);
        req_pc_d = pc_q;
      end
      if (push_c) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Control state registers
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      out_q    <= 1'b0;
      cnt_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Buffer storage: capture {pc, instr} of a surviving response at the tail
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      fifo_pc_q[0]    <= '0;
      fifo_pc_q[1]    <= '0;
      fifo_instr_q[0] <= '0;
      fifo_instr_q[1] <= '0;
    end else if (push_c) begin
      fifo_pc_q[wr_ptr_q]    <= req_pc_q;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters: accepted instructions and decode back-pressure cycles
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop_c) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (if_valid && !id_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
